// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the memory request controller: region codes, funct3
// encodings, target-select masks and the output-stage state type.
package mem_ctrl_pkg;

   localparam logic [3:0] REGION_IO     = 4'h8;
   localparam logic [3:0] REGION_BIOS   = 4'h4;
   localparam logic [3:0] REGION_DMEM   = 4'h1;
   localparam logic [3:0] REGION_IMEM   = 4'h2;
   localparam logic [3:0] REGION_MIRROR = 4'h3;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // mem_sel is {IMEM, DMEM, BIOS, IO}
   localparam logic [3:0] SEL_IO   = 4'b0001;
   localparam logic [3:0] SEL_BIOS = 4'b0010;
   localparam logic [3:0] SEL_DMEM = 4'b0100;
   localparam logic [3:0] SEL_IMEM = 4'b1000;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_ISSUE = 1'b1
   } out_state_t;

   // Stores only know B/H/W; loads additionally accept the unsigned variants.
   function automatic logic f3_supported(input logic is_store, input logic [2:0] f3);
      logic ok;
      ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
      if (!is_store) begin
         ok = ok || (f3 == F3_BU) || (f3 == F3_HU);
      end
      return ok;
   endfunction

endpackage

// File: rtl/ld_meta_fifo.sv
// Small in-order FIFO holding {funct3, addr[1:0]} for each outstanding load,
// with show-ahead head data and an occupancy count.
module ld_meta_fifo
   import mem_ctrl_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int WIDTH = 5
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_push_data,
   input  logic                     i_pop,
   output logic [WIDTH-1:0]         o_head,
   output logic [$clog2(DEPTH):0]   o_count,
   output logic                     o_empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             w_do_push;
   logic             w_do_pop;

   assign w_do_pop  = i_pop && (r_count != '0);
   assign w_do_push = i_push && (r_count != CW'(DEPTH));

   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr] <= i_push_data;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_head  = r_mem[r_rd_ptr];
   assign o_count = r_count;
   assign o_empty = (r_count == '0);

endmodule

// File: rtl/mem_req_ctrl.sv
// Pipeline-to-memory request controller: decodes and legalises requests, drives
// a registered target handshake, and returns in-order, extended load data.
module mem_req_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int XLEN              = 32,
   parameter int MAX_OUT           = 4,
   parameter bit IMEM_WR_BIOS_ONLY = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_req_valid,
   output logic              o_req_ready,
   input  logic              i_req_is_store,
   input  logic [2:0]        i_req_funct3,
   input  logic [XLEN-1:0]   i_req_addr,
   input  logic [XLEN-1:0]   i_req_wdata,
   input  logic [XLEN-1:0]   i_req_pc,
   output logic              o_mem_valid,
   input  logic              i_mem_ready,
   output logic [XLEN-1:0]   o_mem_addr,
   output logic [XLEN-1:0]   o_mem_wdata,
   output logic [XLEN/8-1:0] o_mem_we,
   output logic [3:0]        o_mem_sel,
   input  logic              i_mem_rsp_valid,
   input  logic [XLEN-1:0]   i_mem_rsp_data,
   output logic              o_ld_valid,
   output logic [XLEN-1:0]   o_ld_data,
   output logic              o_fault,
   output logic              o_stall,
   output logic              o_rsp_err
);

   localparam int BW = XLEN / 8;
   localparam int CW = $clog2(MAX_OUT) + 1;

   out_state_t        r_state;
   out_state_t        w_next_state;
   logic [XLEN-1:0]   r_mem_addr;
   logic [XLEN-1:0]   r_mem_wdata;
   logic [BW-1:0]     r_mem_we;
   logic [3:0]        r_mem_sel;
   logic              r_fault;
   logic              r_ld_valid;
   logic [XLEN-1:0]   r_ld_data;
   logic              r_rsp_err;

   logic [3:0]        w_region;
   logic [1:0]        w_offs;
   logic              w_imem_wr_ok;
   logic [3:0]        w_sel;
   logic              w_misaligned;
   logic              w_legal;
   logic [BW-1:0]     w_we;
   logic [XLEN-1:0]   w_wdata;
   logic              w_accept;
   logic              w_issue;
   logic              w_push;
   logic              w_pop;
   logic [4:0]        w_head;
   logic [CW-1:0]     w_count;
   logic              w_fifo_empty;
   logic [7:0]        w_byte;
   logic [15:0]       w_half;
   logic [XLEN-1:0]   w_ld_ext;
   logic              w_unused_pc;

   assign w_unused_pc = ^{i_req_pc[XLEN-1:31], i_req_pc[29:0]};

   // Target selection and legality; an empty select means unmapped.
   always_comb begin
      w_region     = i_req_addr[31:28];
      w_offs       = i_req_addr[1:0];
      w_imem_wr_ok = !IMEM_WR_BIOS_ONLY || i_req_pc[30];
      w_sel        = '0;
      if (i_req_is_store) begin
         case (w_region)
            REGION_IO:     w_sel = SEL_IO;
            REGION_DMEM:   w_sel = SEL_DMEM;
            REGION_IMEM:   w_sel = w_imem_wr_ok ? SEL_IMEM : 4'b0000;
            REGION_MIRROR: w_sel = SEL_DMEM | (w_imem_wr_ok ? SEL_IMEM : 4'b0000);
            default:       w_sel = '0;
         endcase
      end else begin
         case (w_region)
            REGION_IO:     w_sel = SEL_IO;
            REGION_BIOS:   w_sel = SEL_BIOS;
            REGION_DMEM:   w_sel = SEL_DMEM;
            REGION_MIRROR: w_sel = SEL_DMEM;
            default:       w_sel = '0;
         endcase
      end
      w_misaligned = ((i_req_funct3[1:0] == 2'b01) && w_offs[0])
                   || ((i_req_funct3[1:0] == 2'b10) && (w_offs != 2'b00));
      w_legal      = (w_sel != 4'b0000) && !w_misaligned
                   && f3_supported(i_req_is_store, i_req_funct3);
   end

   always_comb begin
      w_we    = '0;
      w_wdata = i_req_wdata;
      if (i_req_is_store) begin
         case (i_req_funct3)
            F3_B: begin
               w_we    = {{(BW-1){1'b0}}, 1'b1} << w_offs;
               w_wdata = {BW{i_req_wdata[7:0]}};
            end
            F3_H: begin
               w_we    = {{(BW-2){1'b0}}, 2'b11} << w_offs;
               w_wdata = {(XLEN/16){i_req_wdata[15:0]}};
            end
            default: w_we = '1;
         endcase
      end
   end

   assign o_req_ready = (!o_mem_valid || i_mem_ready) && (w_count < CW'(MAX_OUT));
   assign o_stall     = i_req_valid && !o_req_ready;
   assign w_accept    = i_req_valid && o_req_ready;
   assign w_issue     = w_accept && w_legal;
   assign w_push      = w_issue && !i_req_is_store;
   assign w_pop       = i_mem_rsp_valid && !w_fifo_empty;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE:  if (w_issue) w_next_state = ST_ISSUE;
         ST_ISSUE: if (i_mem_ready && !w_issue) w_next_state = ST_IDLE;
         default:  w_next_state = ST_IDLE;
      endcase
   end

   always_comb begin
      o_mem_valid = (r_state == ST_ISSUE);
   end

   // Payload is captured on issue and cleared once the target takes it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_mem_we    <= '0;
         r_mem_sel   <= '0;
      end else if (w_issue) begin
         r_mem_addr  <= {i_req_addr[XLEN-1:2], 2'b00};
         r_mem_wdata <= w_wdata;
         r_mem_we    <= w_we;
         r_mem_sel   <= w_sel;
      end else if (o_mem_valid && i_mem_ready) begin
         r_mem_we    <= '0;
         r_mem_sel   <= '0;
      end
   end

   ld_meta_fifo #(
      .DEPTH (MAX_OUT),
      .WIDTH (5)
   ) u_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_push      (w_push),
      .i_push_data ({i_req_funct3, w_offs}),
      .i_pop       (w_pop),
      .o_head      (w_head),
      .o_count     (w_count),
      .o_empty     (w_fifo_empty)
   );

   always_comb begin
      w_byte = i_mem_rsp_data[{w_head[1:0], 3'b000} +: 8];
      w_half = i_mem_rsp_data[{w_head[1], 4'b0000} +: 16];
      case (w_head[4:2])
         F3_B:    w_ld_ext = {{(XLEN-8){w_byte[7]}}, w_byte};
         F3_BU:   w_ld_ext = {{(XLEN-8){1'b0}}, w_byte};
         F3_H:    w_ld_ext = {{(XLEN-16){w_half[15]}}, w_half};
         F3_HU:   w_ld_ext = {{(XLEN-16){1'b0}}, w_half};
         default: w_ld_ext = i_mem_rsp_data;
      endcase
   end

   // Responses with nothing outstanding are dropped and latched as an error.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fault    <= 1'b0;
         r_ld_valid <= 1'b0;
         r_ld_data  <= '0;
         r_rsp_err  <= 1'b0;
      end else begin
         r_fault    <= w_accept && !w_legal;
         r_ld_valid <= w_pop;
         if (w_pop) begin
            r_ld_data <= w_ld_ext;
         end
         if (i_mem_rsp_valid && w_fifo_empty) begin
            r_rsp_err <= 1'b1;
         end
      end
   end

   assign o_mem_addr  = r_mem_addr;
   assign o_mem_wdata = r_mem_wdata;
   assign o_mem_we    = r_mem_we;
   assign o_mem_sel   = r_mem_sel;
   assign o_fault     = r_fault;
   assign o_ld_valid  = r_ld_valid;
   assign o_ld_data   = r_ld_data;
   assign o_rsp_err   = r_rsp_err;

endmodule
